ram8_arbiter: RTL and testbench

- Round-robin arbiter that shares one Hack RAM8 word store (8 x 16-bit, synchronous write, combinational read) between 8 requesters.
- Serialises accesses and drives the single memory port: address, load and write data.
- The memory's internal 1-to-8 load demultiplexer routes mem_load to one word using mem_addr as its 3-bit select.
- Returns read data and a one-hot acknowledge to the winning requester. Sits between CPU/DMA-style masters and a RAM8 instance.

---
 rtl/ram8_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 31 +++
 rtl/ram8_arbiter.sv | 114 +++++++++++
 tb/tb_ram8_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram8_arb_pkg.sv
// Shared constants and state encoding for the RAM8 round-robin arbiter.
package ram8_arb_pkg;

    localparam int unsigned DataW  = 16;
    localparam int unsigned NumReq = 8;
    localparam int unsigned AddrW  = 3;
    localparam int unsigned IdxW   = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 7 -> 0.
module rr_picker
    import ram8_arb_pkg::*;
(
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic              found,
    output logic [IdxW-1:0]   idx
);

    logic [2*NumReq-1:0] dbl;
    logic [NumReq-1:0]   rot;
    logic [IdxW-1:0]     off;

    // Rotate so the bit at ptr lands in position 0.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NumReq-1:0];

    always_comb begin
        off = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IdxW'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = off + ptr;

endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin arbiter serialising 8 requesters onto one RAM8 port.
// Each access takes three cycles: IDLE pick, ISSUE memory cycle, DONE ack.
module ram8_arbiter
    import ram8_arb_pkg::*;
#(
    parameter int unsigned WIDTH  = ram8_arb_pkg::DataW,
    parameter int unsigned N_REQ  = ram8_arb_pkg::NumReq,
    parameter int unsigned ADDR_W = ram8_arb_pkg::AddrW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*WIDTH-1:0]  wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [WIDTH-1:0]        rdata,
    output logic [2:0]              grant_idx,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_load,
    output logic [WIDTH-1:0]        mem_in,
    input  logic [WIDTH-1:0]        mem_out
);

    state_e              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic [2:0]          grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic                mload_q, mload_d;
    logic [WIDTH-1:0]    min_q, min_d;

    logic                pick_found;
    logic [2:0]          pick_idx;

    rr_picker u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        maddr_d = maddr_q;
        mload_d = 1'b0;
        min_d   = min_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StIssue;
                    grant_d = pick_idx;
                    maddr_d = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    min_d   = wdata[int'(pick_idx)*WIDTH +: WIDTH];
                    mload_d = we[pick_idx];
                    busy_d  = 1'b1;
                end
            end
            StIssue: begin
                // A write echoes its own data back as the read result.
                rdata_d        = mload_q ? min_q : mem_out;
                ack_d[grant_q] = 1'b1;
                state_d        = StDone;
            end
            StDone: begin
                ptr_d   = grant_q + 3'd1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            maddr_q <= '0;
            mload_q <= 1'b0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            maddr_q <= maddr_d;
            mload_q <= mload_d;
            min_q   <= min_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign grant_idx = grant_q;
    assign busy      = busy_q;
    assign mem_addr  = maddr_q;
    assign mem_load  = mload_q;
    assign mem_in    = min_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Scoreboard bench for ram8_arbiter with a behavioural RAM8 attached to the memory port.
module tb_ram8_arbiter;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    req = '0;
    logic [7:0]    we = '0;
    logic [23:0]   addr = '0;
    logic [127:0]  wdata = '0;
    logic [7:0]    ack;
    logic [15:0]   rdata;
    logic [2:0]    grant_idx;
    logic          busy;
    logic [2:0]    mem_addr;
    logic          mem_load;
    logic [15:0]   mem_in;
    logic [15:0]   mem_out;

    logic [15:0]   mem [8];
    logic          init_req = 1'b0;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int load_cnt = 0;

    ram8_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .grant_idx (grant_idx),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_load  (mem_load),
        .mem_in    (mem_in),
        .mem_out   (mem_out)
    );

    always #5 clk = ~clk;

    // RAM8 model: synchronous write, combinational read.
    assign mem_out = mem[mem_addr];
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 8; k++) mem[k] <= 16'h00A0 + 16'(k);
        end else if (mem_load) begin
            mem[mem_addr] <= mem_in;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_load) load_cnt <= load_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack is matched against the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && ack != 8'h00) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_onehot", 32'(ack), 32'(8'h01 << e.idx));
                chk("rdata", 32'(rdata), 32'(e.data));
                chk("grant_idx", 32'(grant_idx), 32'(e.idx));
            end
        end
    end

    task automatic start(input int i, input logic w, input logic [2:0] a, input logic [15:0] d);
        req[i] = 1'b1;
        we[i] = w;
        addr[i*3 +: 3] = a;
        wdata[i*16 +: 16] = d;
    endtask

    task automatic wait_ack(output int lat);
        bit seen;
        seen = 0;
        lat = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (ack != 8'h00) seen = 1;
        end
        if (!seen) begin
            chk("ack_timeout", 32'd0, 32'd1);
            lat = -1;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_grant", 32'(grant_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_load", 32'(mem_load), 32'h0);
        chk("rst_mem_in", 32'(mem_in), 32'h0);
    endtask

    initial begin
        int lat;
        int prev_cyc;
        int l0;

        // Reset state, memory preload.
        init_req = 1'b1;
        repeat (2) @(negedge clk);
        init_req = 1'b0;
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during ISSUE of a write to word 5 abandons it.
        start(2, 1'b1, 3'd5, 16'hAAAA);
        @(negedge clk);
        chk("midrst_issue_load", 32'(mem_load), 32'h1);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs();
        chk("midrst_mem5", 32'(mem[5]), 32'h00A5);

        // Round robin with all requesting from reset.
        for (int i = 0; i < 8; i++) start(i, 1'b0, 3'(i), 16'h0);
        for (int k = 0; k < 9; k++) q.push_back('{k % 8, 16'h00A0 + 16'(k % 8)});
        @(negedge clk);
        rst_n = 1'b1;
        prev_cyc = 0;
        for (int k = 0; k < 9; k++) begin
            wait_ack(lat);
            if (k == 0) chk("rr_first_latency", 32'(lat), 32'd2);
            else chk("rr_spacing", 32'(cyc - prev_cyc), 32'd3);
            prev_cyc = cyc;
        end
        req = '0;
        @(negedge clk);

        // Pointer wrap: grant 6, then {6,0} requesting -> 0 first, then 6.
        @(negedge clk);
        start(6, 1'b0, 3'd6, 16'h0);
        q.push_back('{6, 16'h00A6});
        wait_ack(lat);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        start(0, 1'b0, 3'd0, 16'h0);
        start(6, 1'b0, 3'd6, 16'h0);
        q.push_back('{0, 16'h00A0});
        q.push_back('{6, 16'h00A6});
        wait_ack(lat);
        chk("wrap_first", 32'(grant_idx), 32'd0);
        wait_ack(lat);
        chk("wrap_second", 32'(grant_idx), 32'd6);
        chk("wrap_latency", 32'(lat), 32'd3);
        req = '0;
        @(negedge clk);
        @(negedge clk);

        // Single write then read through requester 3.
        l0 = load_cnt;
        start(3, 1'b1, 3'd2, 16'hBEEF);
        q.push_back('{3, 16'hBEEF});
        wait_ack(lat);
        req = '0;
        chk("wr_latency", 32'(lat), 32'd2);
        @(negedge clk);
        chk("wr_load_cycles", 32'(load_cnt - l0), 32'd1);
        chk("wr_mem2", 32'(mem[2]), 32'hBEEF);
        @(negedge clk);
        l0 = load_cnt;
        start(3, 1'b0, 3'd2, 16'h0);
        q.push_back('{3, 16'hBEEF});
        wait_ack(lat);
        req = '0;
        chk("rd_latency", 32'(lat), 32'd2);
        @(negedge clk);
        chk("rd_load_cycles", 32'(load_cnt - l0), 32'd0);
        @(negedge clk);

        // Requester 4 withdraws after one cycle; access still completes.
        start(4, 1'b1, 3'd7, 16'h4444);
        q.push_back('{4, 16'h4444});
        @(negedge clk);
        req = '0;
        wait_ack(lat);
        chk("withdraw_latency", 32'(lat + 1), 32'd2);
        @(negedge clk);
        chk("withdraw_mem7", 32'(mem[7]), 32'h4444);
        @(negedge clk);

        // Winner's inputs change during ISSUE; latched values must be used.
        start(1, 1'b1, 3'd3, 16'h1111);
        q.push_back('{1, 16'h1111});
        @(negedge clk);
        chk("issue_mem_addr", 32'(mem_addr), 32'd3);
        chk("issue_mem_in", 32'(mem_in), 32'h1111);
        chk("issue_busy", 32'(busy), 32'd1);
        addr[1*3 +: 3] = 3'd4;
        wdata[1*16 +: 16] = 16'h2222;
        wait_ack(lat);
        req = '0;
        @(negedge clk);
        chk("latch_mem3", 32'(mem[3]), 32'h1111);
        chk("latch_mem4", 32'(mem[4]), 32'h00A4);
        chk("idle_busy", 32'(busy), 32'd0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
